// File: rtl/sdpram_pkg.sv
// Default geometry for the simple dual-port RAM and the lane-width helper.
package sdpram_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned STRB_WIDTH = 1;
  localparam int unsigned MEM_DEPTH  = 2 ** ADDR_WIDTH;

  function automatic int unsigned lane_width(input int unsigned dw, input int unsigned sw);
    return dw / sw;
  endfunction

endpackage

// File: rtl/sdpram_if.sv
// Write port A / read port B bundle for simple_dual_port_ram; carries no clock.
interface sdpram_if #(
  parameter int unsigned DATA_WIDTH = sdpram_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = sdpram_pkg::ADDR_WIDTH,
  parameter int unsigned STRB_WIDTH = sdpram_pkg::STRB_WIDTH,
  parameter int unsigned MEM_DEPTH  = 2 ** ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] addra;
  logic [STRB_WIDTH-1:0] wena;
  logic [DATA_WIDTH-1:0] dina;
  logic [ADDR_WIDTH-1:0] addrb;
  logic                  renb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  dvalb;

  modport ram (
    input  addra, wena, dina, addrb, renb,
    output doutb, dvalb
  );

  modport host (
    output addra, wena, dina, addrb, renb,
    input  doutb, dvalb
  );

endinterface

// File: rtl/simple_dual_port_ram.sv
// One-writer / one-reader synchronous RAM with per-lane write strobes and a registered,
// read-first output flagged by dvalb.
module simple_dual_port_ram
  import sdpram_pkg::*;
(
  input logic   clk,
  input logic   rst,
  sdpram_if.ram ifp
);

  localparam int unsigned DW = ifp.DATA_WIDTH;
  localparam int unsigned AW = ifp.ADDR_WIDTH;
  localparam int unsigned SW = ifp.STRB_WIDTH;
  localparam int unsigned MD = ifp.MEM_DEPTH;
  localparam int unsigned LW = lane_width(DW, SW);

  localparam logic [AW:0] DepthLim = (AW + 1)'(MD);

  if ((DW % SW) != 0) begin : g_bad_strb
    $fatal(1, "simple_dual_port_ram: DATA_WIDTH must be a multiple of STRB_WIDTH");
  end

  if (longint'(MD) > (64'd1 << AW)) begin : g_bad_depth
    $fatal(1, "simple_dual_port_ram: MEM_DEPTH exceeds 2**ADDR_WIDTH");
  end

  logic          wr_in_range;
  logic          rd_in_range;
  logic [DW-1:0] rd_word;
  logic [DW-1:0] doutb_q;
  logic          dvalb_q;

  assign wr_in_range = {1'b0, ifp.addra} < DepthLim;
  assign rd_in_range = {1'b0, ifp.addrb} < DepthLim;

  // Each lane owns its own storage so strobed writes never share a driver.
  for (genvar i = 0; i < SW; i++) begin : g_lane
    logic [LW-1:0] mem [MD];

    always_ff @(posedge clk) begin
      if (!rst && ifp.wena[i] && wr_in_range) begin
        mem[ifp.addra] <= ifp.dina[i*LW +: LW];
      end
    end

    assign rd_word[i*LW +: LW] = mem[ifp.addrb];
  end

  // rd_word is sampled before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      doutb_q <= '0;
      dvalb_q <= 1'b0;
    end else begin
      dvalb_q <= ifp.renb;
      if (ifp.renb) begin
        doutb_q <= rd_in_range ? rd_word : '0;
      end
    end
  end

  assign ifp.doutb = doutb_q;
  assign ifp.dvalb = dvalb_q;

endmodule

// File: tb/tb_simple_dual_port_ram.sv
// Scoreboard bench for simple_dual_port_ram: 32-bit words, 4 byte lanes, depth 1000 of 1024.
module tb_simple_dual_port_ram;

  localparam int unsigned Depth = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sdpram_if #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .STRB_WIDTH(4),
    .MEM_DEPTH (Depth)
  ) bus ();

  simple_dual_port_ram dut (
    .clk(clk),
    .rst(rst),
    .ifp(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [1024];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] model_read(input logic [9:0] a);
    return (a < Depth) ? model[a] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // One clock of stimulus. The expected read is taken before this cycle's write is applied
  // to the model (read-first); use_exp substitutes a hand-derived constant for the model.
  task automatic step(input logic r, input logic [3:0] we, input logic [9:0] wa,
                      input logic [31:0] wd, input logic re, input logic [9:0] ra,
                      input logic use_exp, input logic [31:0] exp_val);
    @(posedge clk);
    #1;
    rst       = r;
    bus.wena  = we;
    bus.addra = wa;
    bus.dina  = wd;
    bus.renb  = re;
    bus.addrb = ra;
    if (!r) begin
      if (re) exp_q.push_back(use_exp ? exp_val : model_read(ra));
      if (wa < Depth) begin
        for (int l = 0; l < 4; l++) begin
          if (we[l]) model[wa][8*l +: 8] = wd[8*l +: 8];
        end
      end
    end
  endtask

  initial begin : monitor
    logic [31:0] held;
    logic [31:0] exp_v;
    logic        r_rst;
    logic        r_ren;
    held = 32'h0;
    forever begin
      @(posedge clk);
      r_rst = rst;
      r_ren = bus.renb;
      @(negedge clk);
      if (r_rst) begin
        check("reset_dvalb", {31'h0, bus.dvalb}, 32'h0);
        check("reset_doutb", bus.doutb, 32'h0);
        held = 32'h0;
      end else begin
        check("dvalb", {31'h0, bus.dvalb}, {31'h0, r_ren});
        if (r_ren) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got read data %h, want no read", bus.doutb);
          end else begin
            exp_v = exp_q.pop_front();
            check("read_data", bus.doutb, exp_v);
            held = exp_v;
          end
        end else begin
          check("hold_doutb", bus.doutb, held);
        end
      end
    end
  end

  initial begin : stimulus
    logic [3:0]  we;
    logic [9:0]  wa;
    logic [9:0]  ra;
    logic [31:0] wd;
    logic        re;

    bus.wena  = 4'h0;
    bus.addra = 10'h0;
    bus.dina  = 32'h0;
    bus.renb  = 1'b0;
    bus.addrb = 10'h0;

    // Second reset edge, then fill every in-range word so nothing reads as unknown.
    step(1'b1, 4'h0, 10'h0, 32'h0, 1'b1, 10'h0, 1'b0, 32'h0);
    for (int a = 0; a < int'(Depth); a++) begin
      step(1'b0, 4'hf, 10'(a), 32'($urandom), 1'b0, 10'h0, 1'b0, 32'h0);
    end

    // Basic write then read, then idle to see dvalb drop and doutb hold.
    step(1'b0, 4'hf, 10'h005, 32'hDEADBEEF, 1'b0, 10'h0, 1'b0, 32'h0);
    step(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'h005, 1'b1, 32'hDEADBEEF);
    step(1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0);
    step(1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0);

    // Same-address read/write collision returns the old word.
    step(1'b0, 4'hf, 10'h010, 32'h11111111, 1'b0, 10'h0, 1'b0, 32'h0);
    step(1'b0, 4'hf, 10'h010, 32'h22222222, 1'b1, 10'h010, 1'b1, 32'h11111111);
    step(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'h010, 1'b1, 32'h22222222);

    // Lane strobes 0 and 2 only.
    step(1'b0, 4'hf, 10'h020, 32'hAABBCCDD, 1'b0, 10'h0, 1'b0, 32'h0);
    step(1'b0, 4'b0101, 10'h020, 32'h11223344, 1'b0, 10'h0, 1'b0, 32'h0);
    step(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'h020, 1'b1, 32'hAA22CC44);

    // Out of range and last valid address.
    step(1'b0, 4'hf, 10'd1023, 32'hCAFEF00D, 1'b0, 10'h0, 1'b0, 32'h0);
    step(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'd1023, 1'b1, 32'h0);
    step(1'b0, 4'hf, 10'd999, 32'h12345678, 1'b0, 10'h0, 1'b0, 32'h0);
    step(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'd999, 1'b1, 32'h12345678);

    // Reset mid-stream: the write and read in the reset cycle are ignored, data survives.
    step(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'h005, 1'b1, 32'hDEADBEEF);
    step(1'b1, 4'hf, 10'h005, 32'hBADBAD00, 1'b1, 10'h005, 1'b0, 32'h0);
    step(1'b0, 4'h0, 10'h0, 32'h0, 1'b1, 10'h005, 1'b1, 32'hDEADBEEF);
    step(1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0);

    // Random traffic: write on even cycles, reads at random, some aimed at the write address.
    for (int it = 0; it < 10000; it++) begin
      we = (it % 2 == 0) ? 4'($urandom) : 4'h0;
      wa = 10'($urandom_range(0, 1023));
      wd = 32'($urandom);
      re = 1'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 10'($urandom_range(0, 1023));
      step(1'b0, we, wa, wd, re, ra, 1'b0, 32'h0);
    end

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'h0, 10'h0, 32'h0, 1'b0, 10'h0, 1'b0, 32'h0);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
